alu_mult_seq: RTL and testbench

ALU_MULT_SEQ -- requirements
Module: alu_mult_seq

---
 rtl/alu_mult_seq.sv | 133 +++++++++++++
 tb/tb_alu_mult_seq.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/alu_mult_seq.sv
// alu_mult_seq
// Sequential unsigned 32x32 -> 64 bit shift-and-add multiplier that borrows a
// shared 32-bit adder instead of owning one. Each granted cycle in RUN retires
// one multiplier bit. The HI/LO pair shifts right while partial sums are
// accumulated into HI.
//
// Ports
//   clk      : single clock, all state changes on the rising edge
//   rst_n    : synchronous active-low reset
//   start    : begin a multiply (honoured only in IDLE)
//   mcand    : multiplicand, captured on an accepted start
//   mplier   : multiplier, captured on an accepted start
//   busy     : high while iterating (RUN)
//   done     : one-cycle pulse when the product is complete (DONE)
//   hi, lo   : upper / lower 32 bits of the product register
//   alu_req  : request for the shared ALU, high throughout RUN
//   alu_gnt  : ALU granted this cycle; without it RUN stalls
//   alu_a    : ALU operand a (HI register)
//   alu_b    : ALU operand b (M register)
//   alu_ctr  : ALU control, always add (3'b010)
//   alu_res  : ALU result a+b, combinational from alu_a/alu_b
module alu_mult_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] mcand,
  input  logic [WIDTH-1:0] mplier,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             alu_req,
  input  logic             alu_gnt,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_ctr,
  input  logic [WIDTH-1:0] alu_res
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] hi_q, lo_q, m_q;
  logic [5:0]       cnt_q;
  logic             iterate;
  logic             carry;

  // The shared ALU only returns a 32-bit sum, so the carry out of HI+M is
  // rebuilt from the operand MSBs and the result MSB: a carry occurs when both
  // MSBs are set, or when exactly one is set and the sum MSB came out clear.
  assign carry = (hi_q[WIDTH-1] & m_q[WIDTH-1]) |
                 ((hi_q[WIDTH-1] | m_q[WIDTH-1]) & ~alu_res[WIDTH-1]);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and control outputs. RUN leaves after the granted iteration
  // that retires the last multiplier bit (counter moving from 31 to 32).
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    alu_req = 1'b0;
    iterate = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
        end
      end
      RUN: begin
        busy    = 1'b1;
        alu_req = 1'b1;
        iterate = alu_gnt;
        if (alu_gnt && (cnt_q == 6'(WIDTH - 1))) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath. A set LO[0] adds M into HI (with the rebuilt carry shifted in at
  // the top); a clear LO[0] just shifts. Either way one bit of HI drops into
  // the top of LO and the consumed multiplier bit falls off the bottom.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi_q  <= '0;
      lo_q  <= '0;
      m_q   <= '0;
      cnt_q <= '0;
    end else if (state_q == IDLE && start) begin
      hi_q  <= '0;
      lo_q  <= mplier;
      m_q   <= mcand;
      cnt_q <= '0;
    end else if (iterate) begin
      if (lo_q[0]) begin
        hi_q <= {carry, alu_res[WIDTH-1:1]};
        lo_q <= {alu_res[0], lo_q[WIDTH-1:1]};
      end else begin
        hi_q <= {1'b0, hi_q[WIDTH-1:1]};
        lo_q <= {hi_q[0], lo_q[WIDTH-1:1]};
      end
      cnt_q <= cnt_q + 6'd1;
    end
  end

  assign hi      = hi_q;
  assign lo      = lo_q;
  assign alu_a   = hi_q;
  assign alu_b   = m_q;
  assign alu_ctr = 3'b010;

endmodule

// File: tb/tb_alu_mult_seq.sv
// tb_alu_mult_seq
// Directed bench for alu_mult_seq. The stimulus side issues multiplies and
// pushes the hand-computed product and the cycle at which done must appear
// into a scoreboard queue. A separate monitor pops an entry on every done
// pulse and compares. The shared ALU is modelled as a plain adder.
module tb_alu_mult_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] mcand;
  logic [31:0] mplier;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        alu_req;
  logic        alu_gnt;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_ctr;
  logic [31:0] alu_res;

  typedef struct {
    logic [63:0] prod;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc;
  int   n_checks;
  int   n_fail;

  alu_mult_seq #(.WIDTH(32)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .mcand   (mcand),
    .mplier  (mplier),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo),
    .alu_req (alu_req),
    .alu_gnt (alu_gnt),
    .alu_a   (alu_a),
    .alu_b   (alu_b),
    .alu_ctr (alu_ctr),
    .alu_res (alu_res)
  );

  // Shared ALU: always adds.
  assign alu_res = alu_a + alu_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count rising edges; at a falling edge cyc equals the edges seen so far.
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, actual,
               expected, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding multiply.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("product", {hi, lo}, e.prod);
        checkOutput("done_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  // One multiply. stall_mask[j] drops alu_gnt for edge j after the accepting
  // edge; start_mask[j] re-raises start for edge j; rst_off, when non-zero,
  // asserts reset for that edge and abandons the transaction.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input logic [63:0] prod,
                               input logic [63:0] stall_mask,
                               input logic [63:0] start_mask,
                               input int rst_off);
    int n;
    n = $countones(stall_mask);
    @(negedge clk);
    start   = 1'b1;
    mcand   = a;
    mplier  = b;
    alu_gnt = 1'b1;
    if (rst_off == 0) begin
      sb.push_back('{prod: prod, cyc: cyc + 33 + n});
    end
    @(posedge clk);
    for (int off = 1; off <= 34 + n; off++) begin
      @(negedge clk);
      checkOutput("busy", 64'(busy), 64'((off - 1) <= 31 + n));
      checkOutput("alu_req", 64'(alu_req), 64'((off - 1) <= 31 + n));
      start   = start_mask[off];
      mcand   = ~a;
      mplier  = ~b;
      alu_gnt = ~stall_mask[off];
      rst_n   = (off != rst_off);
      @(posedge clk);
      if (off == rst_off) begin
        @(negedge clk);
        rst_n   = 1'b1;
        start   = 1'b0;
        alu_gnt = 1'b1;
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_alu_req", 64'(alu_req), 64'd0);
        checkOutput("rst_hilo", {hi, lo}, 64'd0);
        return;
      end
    end
    @(negedge clk);
    start   = 1'b0;
    alu_gnt = 1'b1;
    checkOutput("idle_busy", 64'(busy), 64'd0);
    checkOutput("held_product", {hi, lo}, prod);
    checkOutput("scoreboard_drained", 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  logic [63:0] stalls;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    start    = 1'b1;
    mcand    = 32'hFFFF_FFFF;
    mplier   = 32'hFFFF_FFFF;
    alu_gnt  = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_done", 64'(done), 64'd0);
    checkOutput("reset_alu_req", 64'(alu_req), 64'd0);
    checkOutput("reset_hilo", {hi, lo}, 64'd0);
    checkOutput("alu_ctr", 64'(alu_ctr), 64'd2);
    start = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("idle_no_start_busy", 64'(busy), 64'd0);
    checkOutput("idle_hilo", {hi, lo}, 64'd0);

    $display("[TB] 3 * 5");
    applyStimulus(32'd3, 32'd5, 64'h0000_0000_0000_000F, 64'd0, 64'd0, 0);

    $display("[TB] all ones squared");
    applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001,
                  64'd0, 64'd0, 0);

    $display("[TB] zero operands");
    applyStimulus(32'd0, 32'h1234_5678, 64'd0, 64'd0, 64'd0, 0);
    applyStimulus(32'hABCD_EF01, 32'd0, 64'd0, 64'd0, 64'd0, 0);

    $display("[TB] stalled multiply");
    stalls = '0;
    foreach (stalls[i]) begin
      if (i == 3 || i == 4 || i == 8 || i == 12 || i == 16 || i == 17 ||
          i == 21 || i == 26 || i == 29 || i == 31) begin
        stalls[i] = 1'b1;
      end
    end
    applyStimulus(32'h1234_5678, 32'h9ABC_DEF0, 64'h0B00_EA4E_242D_2080,
                  stalls, 64'd0, 0);

    $display("[TB] start ignored in RUN and DONE");
    applyStimulus(32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000,
                  64'd0, (64'd1 << 5) | (64'd1 << 33), 0);

    $display("[TB] reset mid-run");
    applyStimulus(32'hDEAD_BEEF, 32'h0000_0002, 64'd0, 64'd0, 64'd0, 17);
    applyStimulus(32'd7, 32'd6, 64'd42, 64'd0, 64'd0, 0);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
